dafx_axi_reg_master: RTL

// Command-driven AXI4 initiator for the dafx register space. Converts one

---
 rtl/dafx_axi_master_pkg.sv | 26 ++
 rtl/axi4_reg_if.sv | 72 +++++++
 rtl/dafx_axi_reg_master.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/dafx_axi_master_pkg.sv
// Shared types and constants for the dafx AXI4 register master.
package dafx_axi_master_pkg;

    // Transaction FSM states of the command-driven master
    typedef enum logic [2:0] {
        IDLE_E,
        AW_E,
        W_E,
        B_E,
        AR_E,
        R_E,
        DONE_E
    } dafx_axi_mst_state_t;

    localparam int          AXI_ID_WIDTH_C   = 4;
    localparam logic [1:0]  AXI_BURST_INCR_C = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY_C  = 2'b00;
    localparam logic [1:0]  DAFX_LEN_ERR_C   = 2'b11;

    // The first non-OKAY response of a burst sticks; later ones are dropped.
    function automatic logic [1:0] merge_resp(input logic [1:0] acc,
                                              input logic [1:0] resp);
        return (acc != AXI_RESP_OKAY_C) ? acc : resp;
    endfunction

endpackage

// File: rtl/axi4_reg_if.sv
// AXI4 register-space bus with master and slave views.
interface axi4_reg_if
    import dafx_axi_master_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64
) (
    input logic clk,
    input logic rst_n
);

    logic [AXI_ID_WIDTH_C-1:0] awid;
    logic [ADDR_W-1:0]         awaddr;
    logic [7:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic                      awvalid;
    logic                      awready;

    logic [DATA_W-1:0]         wdata;
    logic [DATA_W/8-1:0]       wstrb;
    logic                      wlast;
    logic                      wvalid;
    logic                      wready;

    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;

    logic [AXI_ID_WIDTH_C-1:0] arid;
    logic [ADDR_W-1:0]         araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic                      arvalid;
    logic                      arready;

    logic [DATA_W-1:0]         rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      rvalid;
    logic                      rready;

    modport master (
        input  clk, rst_n,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  clk, rst_n,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/dafx_axi_reg_master.sv
// Command-driven AXI4 initiator: turns one read/write INCR burst command
// into AW/W/B or AR/R traffic and reports a merged completion response.
module dafx_axi_reg_master
    import dafx_axi_master_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH_P = 16,
    parameter int AXI_DATA_WIDTH_P = 64,
    parameter int AXI_ID_P         = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [AXI_ADDR_WIDTH_P-1:0] cmd_addr,
    input  logic [7:0]                  cmd_len,
    input  logic [AXI_DATA_WIDTH_P-1:0] wr_data,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    output logic [AXI_DATA_WIDTH_P-1:0] rd_data,
    output logic                        rd_valid,
    output logic                        rd_last,
    input  logic                        rd_ready,
    output logic                        cmd_done,
    output logic [1:0]                  cmd_resp,
    axi4_reg_if.master                  mst
);

    localparam logic [2:0] AXI_SIZE_C = 3'($clog2(AXI_DATA_WIDTH_P / 8));

    dafx_axi_mst_state_t          state_q, state_d;
    logic                         cmd_ready_q, cmd_ready_d;
    logic                         awvalid_q, awvalid_d;
    logic                         arvalid_q, arvalid_d;
    logic                         bready_q, bready_d;
    logic                         cmd_done_q, cmd_done_d;
    logic [1:0]                   cmd_resp_q, cmd_resp_d;
    logic [AXI_ADDR_WIDTH_P-1:0]  addr_q, addr_d;
    logic [7:0]                   len_q, len_d;
    logic [7:0]                   cnt_q, cnt_d;
    logic [1:0]                   resp_q, resp_d;
    logic                         len_err_q, len_err_d;

    logic [1:0]                   resp_next;
    logic                         len_err_next;

    // State register; reset parks the FSM in IDLE with every handshake low
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE_E;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            cmd_done_q  <= 1'b0;
            cmd_resp_q  <= AXI_RESP_OKAY_C;
            addr_q      <= '0;
            len_q       <= 8'd0;
            cnt_q       <= 8'd0;
            resp_q      <= AXI_RESP_OKAY_C;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            cmd_done_q  <= cmd_done_d;
            cmd_resp_q  <= cmd_resp_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            resp_q      <= resp_d;
            len_err_q   <= len_err_d;
        end
    end

    // Next-state logic; the beat counter runs down from len and only the
    // read path uses it as a cross-check against the slave's rlast
    always_comb begin
        state_d      = state_q;
        cmd_ready_d  = cmd_ready_q;
        awvalid_d    = awvalid_q;
        arvalid_d    = arvalid_q;
        bready_d     = bready_q;
        cmd_done_d   = 1'b0;
        cmd_resp_d   = AXI_RESP_OKAY_C;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        resp_d       = resp_q;
        len_err_d    = len_err_q;
        resp_next    = resp_q;
        len_err_next = len_err_q;

        case (state_q)
            IDLE_E: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    addr_d      = cmd_addr;
                    len_d       = cmd_len;
                    cnt_d       = cmd_len;
                    resp_d      = AXI_RESP_OKAY_C;
                    len_err_d   = 1'b0;
                    cmd_ready_d = 1'b0;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        state_d   = AW_E;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = AR_E;
                    end
                end
            end

            AW_E: begin
                if (mst.awready) begin
                    awvalid_d = 1'b0;
                    state_d   = W_E;
                end
            end

            W_E: begin
                if (wr_valid && mst.wready) begin
                    if (cnt_q == 8'd0) begin
                        bready_d = 1'b1;
                        state_d  = B_E;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end

            B_E: begin
                if (mst.bvalid) begin
                    resp_next  = merge_resp(resp_q, mst.bresp);
                    resp_d     = resp_next;
                    bready_d   = 1'b0;
                    cmd_done_d = 1'b1;
                    cmd_resp_d = resp_next;
                    state_d    = DONE_E;
                end
            end

            AR_E: begin
                if (mst.arready) begin
                    arvalid_d = 1'b0;
                    state_d   = R_E;
                end
            end

            R_E: begin
                if (mst.rvalid && rd_ready) begin
                    resp_next = merge_resp(resp_q, mst.rresp);
                    resp_d    = resp_next;
                    if (mst.rlast) begin
                        if (cnt_q != 8'd0) begin
                            len_err_next = 1'b1;
                        end
                    end else begin
                        if (cnt_q == 8'd0) begin
                            len_err_next = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end
                    len_err_d = len_err_next;
                    if (mst.rlast) begin
                        cmd_done_d = 1'b1;
                        cmd_resp_d = len_err_next ? DAFX_LEN_ERR_C : resp_next;
                        state_d    = DONE_E;
                    end
                end
            end

            DONE_E: begin
                cmd_ready_d = 1'b1;
                state_d     = IDLE_E;
            end

            default: begin
                state_d = IDLE_E;
            end
        endcase
    end

    // Bus and host-side outputs; W and R data paths are pure passthroughs
    always_comb begin
        mst.awid    = AXI_ID_WIDTH_C'(AXI_ID_P);
        mst.awaddr  = addr_q;
        mst.awlen   = len_q;
        mst.awsize  = AXI_SIZE_C;
        mst.awburst = AXI_BURST_INCR_C;
        mst.awvalid = awvalid_q;

        mst.wdata   = wr_data;
        mst.wstrb   = '1;
        mst.wlast   = (state_q == W_E) && (cnt_q == 8'd0);
        mst.wvalid  = (state_q == W_E) && wr_valid;
        wr_ready    = (state_q == W_E) && mst.wready;

        mst.bready  = bready_q;

        mst.arid    = AXI_ID_WIDTH_C'(AXI_ID_P);
        mst.araddr  = addr_q;
        mst.arlen   = len_q;
        mst.arsize  = AXI_SIZE_C;
        mst.arburst = AXI_BURST_INCR_C;
        mst.arvalid = arvalid_q;

        mst.rready  = (state_q == R_E) && rd_ready;
        rd_valid    = (state_q == R_E) && mst.rvalid;
        rd_data     = mst.rdata;
        rd_last     = mst.rlast;

        cmd_ready   = cmd_ready_q;
        cmd_done    = cmd_done_q;
        cmd_resp    = cmd_resp_q;
    end

endmodule
